// File: rtl/key_event_sched_pkg.sv
// Shared event codes, arbitration order and types for the key event scheduler.
package calc_pkg;

    localparam int unsigned EV_W       = 3;
    localparam int unsigned SW_W       = 8;
    localparam int unsigned EV_NUM     = 7;
    localparam int unsigned EV_ENTRY_W = EV_W + SW_W;

    localparam logic [EV_W-1:0] EV_LEFT     = 3'd1;
    localparam logic [EV_W-1:0] EV_K1       = 3'd2;
    localparam logic [EV_W-1:0] EV_RIGHT    = 3'd3;
    localparam logic [EV_W-1:0] EV_K4       = 3'd4;
    localparam logic [EV_W-1:0] EV_S2_SHORT = 3'd5;
    localparam logic [EV_W-1:0] EV_S2_LONG  = 3'd6;
    localparam logic [EV_W-1:0] EV_SW_CHG   = 3'd7;

    // Highest priority first.
    localparam logic [EV_W-1:0] EV_PRIO [EV_NUM] = '{
        EV_S2_LONG, EV_S2_SHORT, EV_LEFT, EV_RIGHT, EV_K1, EV_K4, EV_SW_CHG
    };

    typedef enum logic [1:0] {
        S2_IDLE,
        S2_PRESS,
        S2_HELD
    } s2_state_t;

    typedef struct packed {
        logic [EV_W-1:0] code;
        logic [SW_W-1:0] data;
    } ev_entry_t;

endpackage

// File: rtl/key_event_sched_fifo.sv
// Small synchronous event FIFO; head is read combinationally from the read pointer.
module ev_fifo
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = EV_ENTRY_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_sched.sv
// Turns debounced key pulses, S2 level and switch changes into one prioritised,
// FIFO-buffered event stream for the calculator FSM.
module key_event_sched
    import calc_pkg::*;
#(
    parameter int unsigned LONG_TICKS = 100,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk_db,
    input  logic            rst,
    input  logic            s0_p,
    input  logic            s1_p,
    input  logic            s2_lvl,
    input  logic            s3_p,
    input  logic            s4_p,
    input  logic [SW_W-1:0] sw,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [EV_W-1:0] ev_code,
    output logic [SW_W-1:0] ev_data,
    output logic            s2_holding,
    output logic            ovf
);

    localparam int unsigned      CW       = $clog2(LONG_TICKS + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(LONG_TICKS - 1);

    s2_state_t         r_s2_state;
    logic [CW-1:0]     r_s2_cnt;
    logic              r_s2_holding;
    logic [SW_W-1:0]   r_sw_prev;
    logic [EV_NUM:1]   r_pend;
    logic              r_ovf;

    logic              w_raise_short;
    logic              w_raise_long;
    logic              w_sw_chg;
    logic [EV_NUM:1]   w_raised;
    logic [EV_NUM:1]   w_grant;
    logic [EV_W-1:0]   w_push_code;
    logic [SW_W-1:0]   w_push_data;
    logic              w_push;
    logic              w_pop;
    logic              w_can_push;
    logic              w_full;
    logic              w_empty;
    ev_entry_t         w_head;

    always_ff @(posedge clk_db or posedge rst) begin
        if (rst) begin
            r_s2_state   <= S2_IDLE;
            r_s2_cnt     <= '0;
            r_s2_holding <= 1'b0;
        end else begin
            case (r_s2_state)
                S2_IDLE: begin
                    if (s2_lvl) begin
                        r_s2_state   <= S2_PRESS;
                        r_s2_cnt     <= CW'(1);
                        r_s2_holding <= 1'b1;
                    end
                end
                S2_PRESS: begin
                    if (!s2_lvl) begin
                        r_s2_state   <= S2_IDLE;
                        r_s2_holding <= 1'b0;
                    end else if (r_s2_cnt == CNT_LAST) begin
                        r_s2_state   <= S2_HELD;
                        r_s2_holding <= 1'b0;
                    end else begin
                        r_s2_cnt <= r_s2_cnt + CW'(1);
                    end
                end
                S2_HELD: begin
                    if (!s2_lvl) begin
                        r_s2_state <= S2_IDLE;
                    end
                end
                default: begin
                    r_s2_state   <= S2_IDLE;
                    r_s2_holding <= 1'b0;
                end
            endcase
        end
    end

    assign w_raise_short = (r_s2_state == S2_PRESS) & ~s2_lvl;
    assign w_raise_long  = (r_s2_state == S2_PRESS) & s2_lvl & (r_s2_cnt == CNT_LAST);
    assign w_sw_chg      = (sw != r_sw_prev);
    assign w_raised      = {w_sw_chg, w_raise_long, w_raise_short, s4_p, s3_p, s1_p, s0_p};

    assign ev_valid   = ~w_empty;
    assign w_pop      = ev_valid & ev_ready;
    assign w_can_push = ~w_full | w_pop;

    // Walk lowest to highest priority so the last hit is the winner.
    always_comb begin
        w_grant     = '0;
        w_push_code = '0;
        if (w_can_push) begin
            for (int unsigned i = 0; i < EV_NUM; i++) begin
                if (r_pend[EV_PRIO[EV_NUM-1-i]]) begin
                    w_grant                      = '0;
                    w_grant[EV_PRIO[EV_NUM-1-i]] = 1'b1;
                    w_push_code                  = EV_PRIO[EV_NUM-1-i];
                end
            end
        end
    end

    assign w_push = |w_grant;
    // The switch snapshot always equals the last sampled sw, so sw_prev doubles as it.
    assign w_push_data = (w_push_code == EV_SW_CHG) ? r_sw_prev : '0;

    always_ff @(posedge clk_db or posedge rst) begin
        if (rst) begin
            r_pend    <= '0;
            r_ovf     <= 1'b0;
            r_sw_prev <= '0;
        end else begin
            r_pend    <= (r_pend & ~w_grant) | w_raised;
            r_sw_prev <= sw;
            if (|(w_raised[EV_NUM-1:1] & r_pend[EV_NUM-1:1] & ~w_grant[EV_NUM-1:1])) begin
                r_ovf <= 1'b1;
            end
        end
    end

    ev_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_ENTRY_W)
    ) u_fifo (
        .i_clk   (clk_db),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_wdata ({w_push_code, w_push_data}),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign ev_code    = w_empty ? '0 : w_head.code;
    assign ev_data    = w_empty ? '0 : w_head.data;
    assign s2_holding = r_s2_holding;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_key_event_sched.sv
// Self-checking bench: fixed vector table, directed corner sequences and random
// stimulus, all compared against a queue-based event model.
module tb_key_event_sched;

    localparam int LT    = 100;
    localparam int DEPTH = 4;

    logic       clk_db = 1'b0;
    logic       rst    = 1'b0;
    logic       s0_p = 1'b0, s1_p = 1'b0, s2_lvl = 1'b0, s3_p = 1'b0, s4_p = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic [7:0] ev_data;
    logic       s2_holding;
    logic       ovf;

    key_event_sched #(
        .LONG_TICKS (LT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_db     (clk_db),
        .rst        (rst),
        .s0_p       (s0_p),
        .s1_p       (s1_p),
        .s2_lvl     (s2_lvl),
        .s3_p       (s3_p),
        .s4_p       (s4_p),
        .sw         (sw),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_data    (ev_data),
        .s2_holding (s2_holding),
        .ovf        (ovf)
    );

    always #5 clk_db = ~clk_db;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: event queue, per-code pending flags, S2 run length.
    bit [10:0] mq[$];
    bit [7:1]  m_pend;
    int        m_run;
    bit [7:0]  m_swp;
    bit [7:0]  m_snap;
    bit        m_ovf;
    int        prio[7] = '{6, 5, 1, 3, 2, 4, 7};
    bit [10:0] obs[$];

    task automatic model_reset();
        mq.delete();
        m_pend = '0;
        m_run  = 0;
        m_swp  = 8'h00;
        m_snap = 8'h00;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step();
        bit [7:1] raised;
        int       g;
        bit       pop;
        bit [7:0] gd;
        raised = '0;
        g      = 0;
        gd     = 8'h00;
        raised[1] = s0_p;
        raised[2] = s1_p;
        raised[3] = s3_p;
        raised[4] = s4_p;
        if (s2_lvl) begin
            m_run++;
            if (m_run == LT) raised[6] = 1'b1;
        end else begin
            if (m_run > 0 && m_run < LT) raised[5] = 1'b1;
            m_run = 0;
        end
        if (sw != m_swp) raised[7] = 1'b1;
        pop = (mq.size() > 0) && ev_ready;
        if (mq.size() < DEPTH || pop) begin
            foreach (prio[k]) begin
                if (g == 0 && m_pend[prio[k]]) g = prio[k];
            end
        end
        if (g == 7) gd = m_snap;
        for (int c = 1; c <= 6; c++) begin
            if (raised[c] && m_pend[c] && c != g) m_ovf = 1'b1;
        end
        if (g != 0) m_pend[g] = 1'b0;
        m_pend = m_pend | raised;
        if (raised[7]) m_snap = sw;
        m_swp = sw;
        if (pop) void'(mq.pop_front());
        if (g != 0) mq.push_back({3'(g), gd});
    endtask

    task automatic cycle();
        if (ev_valid && ev_ready) obs.push_back({ev_code, ev_data});
        @(posedge clk_db);
        if (!rst) model_step();
        #1;
        chk("valid", int'(ev_valid), int'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("code", int'(ev_code), int'(mq[0][10:8]));
            chk("data", int'(ev_data), int'(mq[0][7:0]));
        end
        chk("s2_holding", int'(s2_holding), int'(m_run > 0 && m_run < LT));
        chk("ovf", int'(ovf), int'(m_ovf));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        chk("rst ev_valid", int'(ev_valid), 0);
        chk("rst ev_code", int'(ev_code), 0);
        chk("rst ev_data", int'(ev_data), 0);
        chk("rst s2_holding", int'(s2_holding), 0);
        chk("rst ovf", int'(ovf), 0);
        @(negedge clk_db);
        rst = 1'b0;
    endtask

    task automatic pulse(input bit a0, input bit a1, input bit a3, input bit a4);
        s0_p = a0; s1_p = a1; s3_p = a3; s4_p = a4;
        cycle();
        s0_p = 1'b0; s1_p = 1'b0; s3_p = 1'b0; s4_p = 1'b0;
    endtask

    function automatic int obs_code(input int i);
        return (i < obs.size()) ? int'(obs[i][10:8]) : -1;
    endfunction

    function automatic int obs_data(input int i);
        return (i < obs.size()) ? int'(obs[i][7:0]) : -1;
    endfunction

    typedef struct {
        bit       s0, s1, s3, s4;
        bit [7:0] sw;
        bit       rdy;
        bit       ev;
        bit [2:0] ec;
        bit [7:0] ed;
    } vec_t;

    vec_t tv[16];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{1, 0, 0, 0, 8'h00, 1, 0, 3'd0, 8'h00};
        tv[1]  = '{0, 0, 0, 0, 8'h00, 1, 1, 3'd1, 8'h00};
        tv[2]  = '{0, 0, 0, 0, 8'h00, 1, 0, 3'd0, 8'h00};
        tv[3]  = '{1, 1, 1, 1, 8'h00, 1, 0, 3'd0, 8'h00};
        tv[4]  = '{0, 0, 0, 0, 8'h00, 1, 1, 3'd1, 8'h00};
        tv[5]  = '{0, 0, 0, 0, 8'h00, 1, 1, 3'd3, 8'h00};
        tv[6]  = '{0, 0, 0, 0, 8'h00, 1, 1, 3'd2, 8'h00};
        tv[7]  = '{0, 0, 0, 0, 8'h00, 1, 1, 3'd4, 8'h00};
        tv[8]  = '{0, 0, 0, 0, 8'h00, 1, 0, 3'd0, 8'h00};
        tv[9]  = '{0, 0, 0, 0, 8'h5A, 1, 0, 3'd0, 8'h00};
        tv[10] = '{0, 0, 0, 0, 8'h5A, 1, 1, 3'd7, 8'h5A};
        tv[11] = '{0, 0, 0, 0, 8'h5A, 1, 0, 3'd0, 8'h00};
        tv[12] = '{0, 1, 0, 0, 8'h5A, 0, 0, 3'd0, 8'h00};
        tv[13] = '{0, 0, 0, 0, 8'h5A, 0, 1, 3'd2, 8'h00};
        tv[14] = '{0, 0, 0, 0, 8'h5A, 0, 1, 3'd2, 8'h00};
        tv[15] = '{0, 0, 0, 0, 8'h5A, 1, 0, 3'd0, 8'h00};

        #1;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            s0_p = tv[i].s0; s1_p = tv[i].s1; s3_p = tv[i].s3; s4_p = tv[i].s4;
            sw = tv[i].sw; ev_ready = tv[i].rdy;
            cycle();
            chk($sformatf("vec%0d valid", i), int'(ev_valid), int'(tv[i].ev));
            if (tv[i].ev) begin
                chk($sformatf("vec%0d code", i), int'(ev_code), int'(tv[i].ec));
                chk($sformatf("vec%0d data", i), int'(ev_data), int'(tv[i].ed));
            end
        end
        s0_p = 1'b0; s1_p = 1'b0; s3_p = 1'b0; s4_p = 1'b0;

        // S2 held 99 samples: one short press.
        ev_ready = 1'b1;
        obs.delete();
        s2_lvl = 1'b1;
        repeat (99) cycle();
        chk("s2 99 holding", int'(s2_holding), 1);
        s2_lvl = 1'b0;
        cycle();
        chk("s2 99 release holding", int'(s2_holding), 0);
        repeat (4) cycle();
        chk("s2 short count", obs.size(), 1);
        chk("s2 short code", obs_code(0), 5);

        // S2 held 100 samples with three key pulses on the long-press edge.
        obs.delete();
        s2_lvl = 1'b1;
        repeat (99) cycle();
        chk("s2 long pre holding", int'(s2_holding), 1);
        pulse(1'b1, 1'b1, 1'b1, 1'b0);
        chk("s2 long holding", int'(s2_holding), 0);
        repeat (3) cycle();
        s2_lvl = 1'b0;
        repeat (6) cycle();
        chk("prio count", obs.size(), 4);
        chk("prio 0", obs_code(0), 6);
        chk("prio 1", obs_code(1), 1);
        chk("prio 2", obs_code(2), 3);
        chk("prio 3", obs_code(3), 2);

        // Back-pressure: FIFO fills, LEFT and SW_CHG wait, second LEFT overflows.
        ev_ready = 1'b0;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        s2_lvl = 1'b1;
        repeat (3) cycle();
        s2_lvl = 1'b0;
        cycle();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        sw = 8'h33;
        repeat (3) cycle();
        chk("full valid", int'(ev_valid), 1);
        chk("full head", int'(ev_code), 2);
        chk("full ovf before", int'(ovf), 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovf on dup LEFT", int'(ovf), 1);
        obs.delete();
        ev_ready = 1'b1;
        repeat (10) cycle();
        chk("drain count", obs.size(), 6);
        chk("drain 0", obs_code(0), 2);
        chk("drain 1", obs_code(1), 3);
        chk("drain 2", obs_code(2), 4);
        chk("drain 3", obs_code(3), 5);
        chk("drain 4", obs_code(4), 1);
        chk("drain 5", obs_code(5), 7);
        chk("drain sw data", obs_data(5), 8'h33);
        chk("ovf sticky", int'(ovf), 1);

        // Reset with three events queued and S2 mid-press.
        ev_ready = 1'b0;
        pulse(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) cycle();
        s2_lvl = 1'b1;
        repeat (5) cycle();
        chk("pre-rst valid", int'(ev_valid), 1);
        chk("pre-rst holding", int'(s2_holding), 1);
        s2_lvl = 1'b0;
        sw = 8'h00;
        do_reset();
        obs.delete();
        ev_ready = 1'b1;
        repeat (6) cycle();
        chk("post-rst events", obs.size(), 0);

        // Switch changes coalesce while the FIFO is full.
        ev_ready = 1'b0;
        pulse(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (4) cycle();
        sw = 8'h05;
        cycle();
        sw = 8'h0A;
        repeat (3) cycle();
        chk("coalesce valid", int'(ev_valid), 1);
        chk("coalesce ovf", int'(ovf), 0);
        obs.delete();
        ev_ready = 1'b1;
        repeat (8) cycle();
        chk("coalesce count", obs.size(), 5);
        chk("coalesce 0", obs_code(0), 1);
        chk("coalesce 1", obs_code(1), 3);
        chk("coalesce 2", obs_code(2), 2);
        chk("coalesce 3", obs_code(3), 4);
        chk("coalesce 4", obs_code(4), 7);
        chk("coalesce data", obs_data(4), 8'h0A);
        chk("coalesce ovf after", int'(ovf), 0);

        // Random traffic against the model; switches preset across reset.
        sw = 8'($urandom);
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            s0_p = ($urandom_range(0, 5) == 0);
            s1_p = ($urandom_range(0, 5) == 0);
            s3_p = ($urandom_range(0, 5) == 0);
            s4_p = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) s2_lvl = ~s2_lvl;
            if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
            if ((n / 300) % 2 == 0) ev_ready = ($urandom_range(0, 3) != 0);
            else                    ev_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 999) == 0) begin
                s0_p = 1'b0; s1_p = 1'b0; s3_p = 1'b0; s4_p = 1'b0;
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
